// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: trellis geometry, traceback FSM states
// and the predecessor function used by both the ACS array and the traceback.
package viterbi_pkg;

  localparam int unsigned K          = 3;
  localparam int unsigned SW         = K - 1;
  localparam int unsigned NUM_STATES = 2 ** SW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MERGE  = 2'd1,
    DECODE = 2'd2,
    OUT    = 2'd3
  } tb_state_e;

  // State = last SW input bits, newest in LSB; the survivor bit supplies the
  // bit that falls off the MSB end when stepping one column back in time.
  function automatic logic [SW-1:0] pred(input logic [SW-1:0] state,
                                         input logic          surv_bit);
    return {surv_bit, state[SW-1:1]};
  endfunction

endpackage

// File: rtl/surv_mem.sv
// Survivor register file: DEPTH columns of WIDTH bits.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata combinational read.
module surv_mem #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi survivor memory and traceback. Stores one survivor column per
// accepted step; every D columns (once 2D are held) it traces back D merge
// steps then D decode steps and emits D decoded bits, bit 0 oldest.
// Ports: clk, rst (sync, active-high); surv_valid/surv_ready/surv_vec/
// best_state column input; dec_valid/dec_bits decoded block; busy.
module traceback_unit #(
  parameter  int unsigned K  = 3,
  parameter  int unsigned D  = 8,
  localparam int unsigned SW = K - 1,
  localparam int unsigned S  = 2 ** SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          surv_valid,
  output logic          surv_ready,
  input  logic [S-1:0]  surv_vec,
  input  logic [SW-1:0] best_state,
  output logic          dec_valid,
  output logic [D-1:0]  dec_bits,
  output logic          busy
);
  import viterbi_pkg::*;

  localparam int unsigned DEPTH = 2 * D;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned FW    = $clog2(DEPTH + 1);
  localparam int unsigned BW    = $clog2(D);

  tb_state_e     state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill_cnt;
  logic [BW-1:0] blk_cnt, step_cnt;
  logic [SW-1:0] tb_state;
  logic [S-1:0]  col_c;
  logic          accept_c, trigger_c, step_last_c;
  logic [PW-1:0] wr_ptr_inc_c, rd_ptr_dec_c;

  surv_mem #(.DEPTH(DEPTH), .WIDTH(S)) u_mem (
    .clk   (clk),
    .we    (accept_c),
    .waddr (wr_ptr),
    .wdata (surv_vec),
    .raddr (rd_ptr),
    .rdata (col_c)
  );

  // Explicit wrap compares keep the ring correct when 2D is not a power of two.
  assign wr_ptr_inc_c = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign rd_ptr_dec_c = (rd_ptr == '0) ? PW'(DEPTH - 1) : rd_ptr - PW'(1);

  assign accept_c    = surv_valid && surv_ready;
  // Fires when this accept fills the buffer to 2D and closes a block of D.
  assign trigger_c   = accept_c && (fill_cnt >= FW'(DEPTH - 1)) &&
                       (blk_cnt == BW'(D - 1));
  assign step_last_c = (step_cnt == BW'(D - 1));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger_c)   state_nxt = MERGE;
      MERGE:   if (step_last_c) state_nxt = DECODE;
      DECODE:  if (step_last_c) state_nxt = OUT;
      OUT:                      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // State register, pointers, traceback datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_cnt   <= '0;
      blk_cnt    <= '0;
      step_cnt   <= '0;
      tb_state   <= '0;
      dec_bits   <= '0;
      dec_valid  <= 1'b0;
      busy       <= 1'b0;
      surv_ready <= 1'b1;
    end else begin
      state <= state_nxt;

      if (accept_c) begin
        wr_ptr  <= wr_ptr_inc_c;
        blk_cnt <= (blk_cnt == BW'(D - 1)) ? '0 : blk_cnt + BW'(1);
        if (fill_cnt != FW'(DEPTH)) fill_cnt <= fill_cnt + FW'(1);
      end

      // The triggering column lands at wr_ptr, which is where tracing starts.
      if (state == IDLE && trigger_c) begin
        tb_state <= best_state;
        rd_ptr   <= wr_ptr;
        step_cnt <= '0;
      end

      if (state == MERGE || state == DECODE) begin
        if (state == DECODE) dec_bits[BW'(D - 1) - step_cnt] <= tb_state[0];
        tb_state <= pred(tb_state, col_c[tb_state]);
        rd_ptr   <= rd_ptr_dec_c;
        step_cnt <= step_last_c ? '0 : step_cnt + BW'(1);
      end

      dec_valid  <= (state_nxt == OUT);
      busy       <= (state_nxt != IDLE);
      surv_ready <= (state_nxt == IDLE);
    end
  end

endmodule

// File: doc/traceback_unit.md
# traceback_unit

Survivor-memory and traceback stage of the Viterbi decoder, directly downstream of the ACS array. Each trellis step it stores one column of survivor bits, one per state, as produced by the per-state ACS cells. After every D new columns, and once 2D columns are held, it runs a register-exchange-free traceback over 2D columns: D merge steps, then D decode steps. It emits a block of D decoded bits in chronological order.

## Interface
- `K`, default 3: constraint length. `SW = K-1` state bits, `S = 2**SW` states.
- `D`, default 8: traceback (merge) depth and decode block length. `D >= 2`.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `surv_valid`, input, 1: survivor column offered.
- `surv_ready`, output, 1: column accepted when `surv_valid && surv_ready`.
- `surv_vec`, input, S: bit s = surv output of the ACS cell for state s. 0 means the predecessor with MSB 0 won.
- `best_state`, input, SW: state with the minimum path metric for the same column.
- `dec_valid`, output, 1: one-cycle pulse; `dec_bits` valid.
- `dec_bits`, output, D: decoded bits. Bit 0 is the oldest.
- `busy`, output, 1: traceback in progress.

## Operation
- State encoding is `s = last SW input bits`, with the newest bit in LSB.
  - Predecessor of s is `{surv_vec[s], s[SW-1:1]}`.
  - The decoded bit for a column at state s is `s[0]`.
- Buffer: circular survivor memory of 2D columns, indexed by `wr_ptr` modulo 2D.
  - On accept: write `surv_vec` at `wr_ptr`, increment `wr_ptr` with wrap, latch `best_state`.
  - `fill_cnt` saturates at 2D. `blk_cnt` counts accepts modulo D.
- Trigger: an accept that makes `fill_cnt == 2D` and `blk_cnt` wrap to 0 starts a traceback in the next cycle.
  - The first traceback follows column 2D; later ones follow every D further columns.
- FSM states:
  - `IDLE`: `surv_ready = 1`. On trigger, load `tb_state = best_state` latched with the triggering column and `rd_ptr = wr_ptr - 1` (mod 2D), then go to `MERGE`.
  - `MERGE` (D cycles): read the column at `rd_ptr` combinationally, set `tb_state <= {col[tb_state], tb_state[SW-1:1]}`, decrement `rd_ptr` with wrap. No output.
  - `DECODE` (D cycles, step i = 0..D-1): first set `dec_bits[D-1-i] <= tb_state[0]`, then update `tb_state` and `rd_ptr` as in `MERGE`.
  - `OUT` (1 cycle): `dec_valid = 1`, then go to `IDLE`.
- Backpressure: `surv_ready = 0` in `MERGE`, `DECODE` and `OUT`, so no column can be overwritten during a traceback.
- `dec_bits` holds its value until the next `OUT`.
- No tail flush. Frame termination (zero-tail) is handled upstream; residual columns are discarded at reset.

## Timing
- Reset values: `surv_ready = 1`, `dec_valid = 0`, `dec_bits = 0`, `busy = 0`, `wr_ptr = 0`, `fill_cnt = 0`, `blk_cnt = 0`, FSM in `IDLE`. Memory contents are don't-care.
- Latency: the triggering column is accepted in cycle T.
  - `MERGE` runs T+1..T+D.
  - `DECODE` runs T+D+1..T+2D.
  - `dec_valid` is high in cycle T+2D+1.
  - `surv_ready` returns to 1 in cycle T+2D+2.
- `surv_ready` falls combinationally from the FSM state in cycle T+1. Upstream must hold `surv_valid`/`surv_vec` stable while ready is low.
- Sustained throughput: D columns per 3D+1 cycles.
- `rst` asserted mid-traceback: the next cycle is in reset state, with no `dec_valid` pulse. The partially traced block is lost and 2D fresh columns are required before the next traceback.
- Pointer wrap: `rd_ptr` wraps from 0 to 2D-1 and `wr_ptr` from 2D-1 to 0. Both must be exercised when D is not a power of two.

## Structure
- Shared package `viterbi_pkg` holds:
  - `K`, `SW`, `NUM_STATES`
  - the `tb_state_e` enum (`IDLE`, `MERGE`, `DECODE`, `OUT`)
  - the predecessor function `pred(state, surv_bit)`, shared with the ACS array.
- Sub-module `surv_mem`: 2D x S register file with one synchronous write port and one combinational read port. Pointer logic stays in `traceback_unit`.

## Test plan
- K=3, D=8: 16 columns with `surv_vec = 4'b0000`, `best_state = 2'b11` -> `dec_valid` once at T+17, `dec_bits = 8'h00`.
- 16 columns with `surv_vec = 4'b1111`, `best_state = 2'b00` -> `dec_bits = 8'hFF`.
- Noiseless path: encode input `8'hA5` followed by `8'h00` and build `surv_vec` so the true predecessors win, with `best_state` = true state -> `dec_bits = 8'hA5`.
- Continuous `surv_valid = 1` for 40 columns -> `surv_ready` low exactly 2D+1 cycles per traceback, no column lost or duplicated, `dec_valid` after columns 16, 24, 32, 40, pointers wrap correctly.
- `rst` pulsed at T+5 of a traceback -> no `dec_valid`, `surv_ready = 1` next cycle, next traceback only after 16 new columns.
- Columns 1..15 only -> no `dec_valid`, `busy` stays 0.
